// File: rtl/transmit_pkg.sv
// Shared types and constants for the transmit photon-click report block.
// Frame length depends on TRANSMIT_PARITY_EN.
package transmit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_INIT      = 2'b01,
        ST_TRANSMIT  = 2'b10,
        ST_TERMINATE = 2'b11
    } state_t;

    localparam logic [1:0] INIT_NONE = 2'b00;
    localparam logic [1:0] INIT_BUSY = 2'b01;
    localparam logic [1:0] INIT_DONE = 2'b10;

`ifdef TRANSMIT_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/transmit_serializer.sv
// UART-style frame shifter: start 0, data LSB first, optional even parity
// (TRANSMIT_PARITY_EN), stop 1. done pulses the cycle after the stop bit.
module transmit_serializer
    import transmit_pkg::*;
#(
    parameter int BIT_CYCLES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       data_out,
    output logic       busy,
    output logic       done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] frame_q, frame_ld;
    logic [CW-1:0]         cyc_q;
    logic [IW-1:0]         idx_q;
    logic                  bit_end, last_bit;

`ifdef TRANSMIT_PARITY_EN
    assign frame_ld = {1'b1, ^data, data, 1'b0};
`else
    assign frame_ld = {1'b1, data, 1'b0};
`endif

    assign bit_end  = (cyc_q == CW'(BIT_CYCLES - 1));
    assign last_bit = (idx_q == IW'(FRAME_BITS - 1));
    assign data_out = frame_q[0];

    // The frame register idles all-ones so the line rests high with no extra mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '1;
            cyc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                frame_q <= frame_ld;
                cyc_q   <= '0;
                idx_q   <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                if (bit_end) begin
                    cyc_q <= '0;
                    if (last_bit) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        frame_q <= '1;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
                    end
                end else begin
                    cyc_q <= cyc_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/transmit.sv
// Photon-click acquisition: init delay, windowed click count, serial report,
// termination hold. Optional parity bit via TRANSMIT_PARITY_EN.
module transmit
    import transmit_pkg::*;
#(
    parameter int INIT_CYCLES   = 40000,
    parameter int WINDOW_CYCLES = 62500,
    parameter int BIT_CYCLES    = 25,
    parameter int TERM_CYCLES   = 2000
) (
    input  logic       clkp,
    input  logic       clkn,
    input  logic       reset,
    input  logic       clicks,
    input  logic       start,
    output logic [1:0] status,
    output logic [1:0] initialization_status,
    output logic       transmission_status,
    output logic       termination_status,
    output logic       ser_done,
    output logic       tim_done,
    output logic [7:0] counterr,
    output logic       data_out
);
    localparam int TMAX = (WINDOW_CYCLES > INIT_CYCLES)
                        ? ((WINDOW_CYCLES > TERM_CYCLES) ? WINDOW_CYCLES : TERM_CYCLES)
                        : ((INIT_CYCLES > TERM_CYCLES) ? INIT_CYCLES : TERM_CYCLES);
    localparam int TW = $clog2(TMAX + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          init_done_q, init_done_d;
    logic [7:0]    cnt_q, cnt_nxt;
    logic [2:0]    sync_q;
    logic          click_edge, count_phase, clr_cnt, ser_busy;

    // clkn only feeds the board-level differential buffer.
    logic unused_clkn;
    assign unused_clkn = clkn;

    assign click_edge  = sync_q[1] & ~sync_q[2];
    assign count_phase = (state_q == ST_TRANSMIT) && !ser_busy && !ser_done;
    assign cnt_nxt     = (click_edge && count_phase && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        init_done_d = init_done_q;
        clr_cnt     = 1'b0;
        tim_done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_INIT;
                tmr_d   = '0;
                clr_cnt = 1'b1;
            end
            ST_INIT: if (tmr_q == TW'(INIT_CYCLES - 1)) begin
                state_d     = ST_TRANSMIT;
                tmr_d       = '0;
                init_done_d = 1'b1;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
            ST_TRANSMIT: if (ser_done) begin
                state_d = ST_TERMINATE;
                tmr_d   = '0;
            end else if (count_phase) begin
                if (tmr_q == TW'(WINDOW_CYCLES - 1)) begin
                    tim_done = 1'b1;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_TERMINATE: if (tmr_q == TW'(TERM_CYCLES - 1)) begin
                tmr_d = '0;
                if (start) begin
                    state_d = ST_INIT;
                    clr_cnt = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkp or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            init_done_q <= 1'b0;
            cnt_q       <= '0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            init_done_q <= init_done_d;
            sync_q      <= {sync_q[1:0], clicks};
            cnt_q       <= clr_cnt ? 8'd0 : cnt_nxt;
        end
    end

    // cnt_nxt is loaded so an edge on the last window clock still makes the frame.
    transmit_serializer #(.BIT_CYCLES(BIT_CYCLES)) u_ser (
        .clk      (clkp),
        .rst      (reset),
        .load     (tim_done),
        .data     (cnt_nxt),
        .data_out (data_out),
        .busy     (ser_busy),
        .done     (ser_done)
    );

    assign status                = state_q;
    assign initialization_status = init_done_q ? INIT_DONE
                                 : (state_q == ST_INIT) ? INIT_BUSY : INIT_NONE;
    assign transmission_status   = (state_q == ST_TRANSMIT);
    assign termination_status    = (state_q == ST_TERMINATE);
    assign counterr              = cnt_q;

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit with shortened timing parameters.
module tb_transmit;
    localparam int INIT   = 40;
    localparam int WINDOW = 1400;
    localparam int BITC   = 5;
    localparam int TERMC  = 50;
`ifdef TRANSMIT_PARITY_EN
    localparam int FB = 11;
    localparam logic [10:0] FRAME_38 = 11'h670;
    localparam logic [10:0] FRAME_FF = 11'h5FE;
`else
    localparam int FB = 10;
    localparam logic [10:0] FRAME_38 = 11'h270;
    localparam logic [10:0] FRAME_FF = 11'h3FE;
`endif

    logic       clkp = 1'b0, reset, clicks, start;
    logic       clkn;
    logic [1:0] status, initialization_status;
    logic       transmission_status, termination_status, ser_done, tim_done, data_out;
    logic [7:0] counterr;
    int         n_chk = 0, n_err = 0;

    always #2 clkp = ~clkp;
    assign clkn = ~clkp;

    transmit #(.INIT_CYCLES(INIT), .WINDOW_CYCLES(WINDOW), .BIT_CYCLES(BITC), .TERM_CYCLES(TERMC)) dut (
        .clkp(clkp), .clkn(clkn), .reset(reset), .clicks(clicks), .start(start),
        .status(status), .initialization_status(initialization_status),
        .transmission_status(transmission_status), .termination_status(termination_status),
        .ser_done(ser_done), .tim_done(tim_done), .counterr(counterr), .data_out(data_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_status(input logic [1:0] v, input int budget, input string tag);
        int n = 0;
        while (status !== v && n < budget) begin
            @(negedge clkp);
            n++;
        end
        chk(tag, {30'd0, status}, {30'd0, v});
    endtask

    // sel 0 waits for tim_done, sel 1 for ser_done
    task automatic wait_pulse(input int sel, input int budget, input string tag);
        int n = 0;
        logic p;
        p = sel ? ser_done : tim_done;
        while (p !== 1'b1 && n < budget) begin
            @(negedge clkp);
            n++;
            p = sel ? ser_done : tim_done;
        end
        chk(tag, {31'd0, p}, 32'd1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            clicks = 1'b1;
            repeat (2) @(negedge clkp);
            clicks = 1'b0;
            repeat (2) @(negedge clkp);
        end
    endtask

    task automatic read_frame(output logic [10:0] f, output logic stable);
        logic first;
        f = '0;
        stable = 1'b1;
        first = 1'b0;
        for (int b = 0; b < FB; b++) begin
            for (int j = 0; j < BITC; j++) begin
                @(negedge clkp);
                if (j == 0) first = data_out;
                else if (data_out !== first) stable = 1'b0;
                if (j == BITC / 2) f[b] = data_out;
            end
        end
    endtask

    // Measures INIT length while toggling clicks, which must not be counted.
    task automatic measure_init(input string tag);
        int n = 0;
        wait_status(2'd1, 5, {tag, "_enter"});
        chk({tag, "_istat_busy"}, {30'd0, initialization_status}, 32'd1);
        while (status === 2'd1 && n < INIT + 10) begin
            clicks = (n < INIT - 8) ? n[1] : 1'b0;
            @(negedge clkp);
            n++;
        end
        clicks = 1'b0;
        chk({tag, "_len"}, n, INIT);
        chk({tag, "_status"}, {30'd0, status}, 32'd2);
        chk({tag, "_istat_done"}, {30'd0, initialization_status}, 32'd2);
        chk({tag, "_cnt"}, {24'd0, counterr}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        logic        st;
        int          n;
        reset = 1'b1; start = 1'b1; clicks = 1'b0;
        repeat (20) @(negedge clkp);
        chk("rst_status", {30'd0, status}, 0);
        chk("rst_istat", {30'd0, initialization_status}, 0);
        chk("rst_tx", {31'd0, transmission_status}, 0);
        chk("rst_term", {31'd0, termination_status}, 0);
        chk("rst_ser_done", {31'd0, ser_done}, 0);
        chk("rst_tim_done", {31'd0, tim_done}, 0);
        chk("rst_cnt", {24'd0, counterr}, 0);
        chk("rst_dout", {31'd0, data_out}, 1);
        reset = 1'b0;
        measure_init("init1");

        // run 1: 56 clicks -> 0x38
        chk("tx_flag", {31'd0, transmission_status}, 1);
        repeat (10) @(negedge clkp);
        pulses(56);
        chk("tx_dout_idle", {31'd0, data_out}, 1);
        wait_pulse(0, WINDOW, "tim_done1");
        chk("cnt56", {24'd0, counterr}, 56);
        read_frame(f, st);
        chk("frame38", {21'd0, f}, {21'd0, FRAME_38});
        chk("frame38_stable", {31'd0, st}, 1);
        wait_pulse(1, 4, "ser_done1");
        @(negedge clkp);
        chk("term_status", {30'd0, status}, 3);
        chk("term_flag", {31'd0, termination_status}, 1);
        for (int i = 0; i < TERMC - 12; i++) begin
            clicks = i[1];
            @(negedge clkp);
        end
        clicks = 1'b0;
        chk("term_cnt_hold", {24'd0, counterr}, 56);
        wait_status(2'd1, 40, "reinit");
        chk("reinit_clr", {24'd0, counterr}, 0);

        // run 2: 300 clicks saturate at 255, then stop to IDLE
        wait_status(2'd2, INIT + 5, "tx2");
        repeat (10) @(negedge clkp);
        pulses(300);
        wait_pulse(0, WINDOW, "tim_done2");
        chk("cnt_sat", {24'd0, counterr}, 255);
        read_frame(f, st);
        chk("frameFF", {21'd0, f}, {21'd0, FRAME_FF});
        wait_pulse(1, 4, "ser_done2");
        start = 1'b0;
        n = 0;
        @(negedge clkp);
        while (status === 2'd3 && n < TERMC + 10) begin
            @(negedge clkp);
            n++;
        end
        chk("term_len", n, TERMC);
        chk("idle_status", {30'd0, status}, 0);
        repeat (5) @(negedge clkp);
        chk("idle_stay", {30'd0, status}, 0);
        chk("idle_cnt_hold", {24'd0, counterr}, 255);
        chk("idle_istat", {30'd0, initialization_status}, 2);
        start = 1'b1;
        @(negedge clkp);
        chk("idle_to_init", {30'd0, status}, 1);
        chk("idle_init_clr", {24'd0, counterr}, 0);

        // run 3: reset in the middle of a frame of 0x05
        wait_status(2'd2, INIT + 5, "tx3");
        repeat (10) @(negedge clkp);
        pulses(5);
        wait_pulse(0, WINDOW, "tim_done3");
        chk("cnt5", {24'd0, counterr}, 5);
        repeat (3 * BITC) @(negedge clkp);
        chk("mid_bit", {31'd0, data_out}, 0);
        reset = 1'b1;
        #1;
        chk("abort_dout", {31'd0, data_out}, 1);
        chk("abort_status", {30'd0, status}, 0);
        chk("abort_cnt", {24'd0, counterr}, 0);
        chk("abort_istat", {30'd0, initialization_status}, 0);
        repeat (20) @(negedge clkp);
        chk("abort_hold", {30'd0, status}, 0);
        reset = 1'b0;
        measure_init("init2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/transmit.md
Name: transmit

Overview:
- NV-controller photon-click acquisition and report block.
- After reset it runs an initialization delay, then counts rising edges of the asynchronous `clicks` detector input over a fixed timing window.
- The 8-bit count is serialized out on `data_out` as a UART-style frame, followed by a termination hold.
- Sits between the detector front-end and the host link.

Parameters:
- INIT_CYCLES, 40000: clocks spent in INIT (160 us at 250 MHz).
- WINDOW_CYCLES, 62500: clocks in the click-counting window (250 us).
- BIT_CYCLES, 25: clocks per serial bit.
- TERM_CYCLES, 2000: clocks held in TERMINATE.

Ports:
- clkp  in  1  System clock, rising edge; positive leg of the differential pair.
- clkn  in  1  Negative leg of the clock pair; used only for the differential input buffer, no logic on it.
- reset  in  1  Asynchronous, active-high reset.
- clicks  in  1  Asynchronous detector pulse input.
- start  in  1  Level enable; run cycles while high.
- status  out  2  FSM state: 00 IDLE, 01 INIT, 10 TRANSMIT, 11 TERMINATE.
- initialization_status  out  2  00 not started, 01 in progress, 10 done.
- transmission_status  out  1  High in TRANSMIT.
- termination_status  out  1  High in TERMINATE.
- ser_done  out  1  One-cycle pulse after the stop bit.
- tim_done  out  1  One-cycle pulse at end of counting window.
- counterr  out  8  Live click count.
- data_out  out  1  Serial output, idles high.

Behaviour:
- Reset values (asynchronous): status=00, initialization_status=00, transmission_status=0, termination_status=0, ser_done=0, tim_done=0, counterr=0, data_out=1, all timers 0.
- Reset asserted mid-operation aborts immediately to IDLE with the above values.
- `clicks` passes through a 2-FF synchronizer plus rising-edge detect, giving 3 clocks of latency to the counter.
  - Click edges outside the counting window are ignored.
  - Minimum click high and low time: 2 clocks.
- IDLE: when start=1 → INIT; clear counterr.
- INIT: initialization_status=01; after INIT_CYCLES clocks → TRANSMIT, and initialization_status=10 (held until reset).
- TRANSMIT, count phase:
  - Timer runs WINDOW_CYCLES clocks; each synchronized click edge increments counterr.
  - counterr saturates at 255.
  - On the last window clock, tim_done pulses and the count is latched into the serializer.
  - An edge coincident with the last window clock is counted.
- TRANSMIT, serialize phase:
  - Frame is start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts BIT_CYCLES clocks.
  - data_out changes only on bit boundaries.
  - After the stop bit, ser_done pulses 1 clock → TERMINATE.
- TERMINATE: termination_status=1 for TERM_CYCLES clocks, then:
  - start=1 → INIT, with counterr cleared on entry.
  - start=0 → IDLE, with counterr holding its last value.
- start deasserted during INIT or TRANSMIT does not abort; the current cycle completes.

Optional Feature:
- TRANSMIT_PARITY_EN defined: an even-parity bit over the 8 data bits is inserted between the data bits and the stop bit (11-bit frame); ser_done timing shifts by BIT_CYCLES.
- Undefined: 10-bit frame, no parity logic.

Decomposition:
- Package transmit_pkg holds:
  - state enum (IDLE/INIT/TRANSMIT/TERMINATE) with the status encodings;
  - initialization_status encodings;
  - frame length constants.
- One sub-module, transmit_serializer:
  - inputs: load, data[7:0];
  - outputs: data_out, busy, done;
  - parameter BIT_CYCLES.
- Synchronizer and counter stay in the top module.

Test Plan:
- Hold reset 80 us with start=1 → all outputs at reset values, data_out=1; after release, status=01 for exactly INIT_CYCLES clocks, then initialization_status=10.
- Release reset, then toggle clicks every 2 us starting 10 us into TRANSMIT, 56 rising edges in total → tim_done pulse, counterr=56.
  - Then data_out frame 0, 0,0,0,1,1,1,0,0, 1 (56 = 0x38), then ser_done pulse.
- 300 click edges inside the window → counterr stops at 255; serialized byte 0xFF.
- Clicks toggled during INIT and TERMINATE → counterr unchanged.
- Assert reset for 8 us mid-serialization → data_out=1 and status=00 immediately; after release, the INIT sequence restarts.
- start=0 during TERMINATE → after TERM_CYCLES, status=00 and counterr holds; build with TRANSMIT_PARITY_EN → 11-bit frame with correct even parity.
